// File: rtl/gen_reg_file.sv
// Parametrised register bank: 2**ADDR_WIDTH words, one write port, two read ports.
// Optional hardwired zero entry, write-to-read bypass and registered read data.
module gen_reg_file #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned ZERO_REG   = 0,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned REG_READ   = 0
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  clear_in,
  input  logic                  wr_en_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [DATA_WIDTH-1:0] wr_data_in,
  input  logic [ADDR_WIDTH-1:0] rd_a_addr_in,
  input  logic [ADDR_WIDTH-1:0] rd_b_addr_in,
  output logic [DATA_WIDTH-1:0] rd_a_data_out,
  output logic [DATA_WIDTH-1:0] rd_b_data_out
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wr_ok_c;
  logic                  byp_ok_c;
  logic [DATA_WIDTH-1:0] rd_a_c;
  logic [DATA_WIDTH-1:0] rd_b_c;

  // Clear beats write; the zero entry never accepts data.
  always_comb begin
    wr_ok_c  = wr_en_in && !clear_in;
    byp_ok_c = wr_ok_c && (BYPASS != 0);
    if ((ZERO_REG != 0) && (wr_addr_in == '0)) begin
      wr_ok_c = 1'b0;
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (clear_in) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok_c) begin
      regs[wr_addr_in] <= wr_data_in;
    end
  end

  // Each read port resolves zero-entry, bypass and stored value independently.
  always_comb begin
    rd_a_c = regs[rd_a_addr_in];
    if ((ZERO_REG != 0) && (rd_a_addr_in == '0)) begin
      rd_a_c = '0;
    end else if (byp_ok_c && (rd_a_addr_in == wr_addr_in)) begin
      rd_a_c = wr_data_in;
    end
  end

  always_comb begin
    rd_b_c = regs[rd_b_addr_in];
    if ((ZERO_REG != 0) && (rd_b_addr_in == '0)) begin
      rd_b_c = '0;
    end else if (byp_ok_c && (rd_b_addr_in == wr_addr_in)) begin
      rd_b_c = wr_data_in;
    end
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      logic [DATA_WIDTH-1:0] rd_a_q;
      logic [DATA_WIDTH-1:0] rd_b_q;

      always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
          rd_a_q <= '0;
          rd_b_q <= '0;
        end else if (clear_in) begin
          rd_a_q <= '0;
          rd_b_q <= '0;
        end else begin
          rd_a_q <= rd_a_c;
          rd_b_q <= rd_b_c;
        end
      end

      assign rd_a_data_out = rd_a_q;
      assign rd_b_data_out = rd_b_q;
    end else begin : g_comb_read
      // Reset also masks the bypass path so outputs read 0 while it is held.
      assign rd_a_data_out = reset_in ? rd_a_c : '0;
      assign rd_b_data_out = reset_in ? rd_b_c : '0;
    end
  endgenerate

endmodule

// File: tb/tb_gen_reg_file.sv
// Directed bench for gen_reg_file: four configurations share one stimulus stream.
module tb_gen_reg_file;

  logic       clk;
  logic       reset_in;
  logic       clear_in;
  logic       wr_en_in;
  logic [1:0] wr_addr_in;
  logic [3:0] wr_data_in;
  logic [1:0] rd_a_addr_in;
  logic [1:0] rd_b_addr_in;

  logic [3:0] a0, b0, a1, b1, az, bz, ar, br;

  int n_checks = 0;
  int n_errors = 0;

  // d0: bypass, comb read; d1: no bypass; dz: zero entry; dr: registered read
  gen_reg_file #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .ZERO_REG(0), .BYPASS(1), .REG_READ(0)) d0 (
    .clock_in(clk), .reset_in(reset_in), .clear_in(clear_in), .wr_en_in(wr_en_in),
    .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in), .rd_a_addr_in(rd_a_addr_in),
    .rd_b_addr_in(rd_b_addr_in), .rd_a_data_out(a0), .rd_b_data_out(b0));

  gen_reg_file #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .ZERO_REG(0), .BYPASS(0), .REG_READ(0)) d1 (
    .clock_in(clk), .reset_in(reset_in), .clear_in(clear_in), .wr_en_in(wr_en_in),
    .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in), .rd_a_addr_in(rd_a_addr_in),
    .rd_b_addr_in(rd_b_addr_in), .rd_a_data_out(a1), .rd_b_data_out(b1));

  gen_reg_file #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .ZERO_REG(1), .BYPASS(1), .REG_READ(0)) dz (
    .clock_in(clk), .reset_in(reset_in), .clear_in(clear_in), .wr_en_in(wr_en_in),
    .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in), .rd_a_addr_in(rd_a_addr_in),
    .rd_b_addr_in(rd_b_addr_in), .rd_a_data_out(az), .rd_b_data_out(bz));

  gen_reg_file #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .ZERO_REG(0), .BYPASS(1), .REG_READ(1)) dr (
    .clock_in(clk), .reset_in(reset_in), .clear_in(clear_in), .wr_en_in(wr_en_in),
    .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in), .rd_a_addr_in(rd_a_addr_in),
    .rd_b_addr_in(rd_b_addr_in), .rd_a_data_out(ar), .rd_b_data_out(br));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic en, input logic [1:0] addr, input logic [3:0] data);
    wr_en_in   = en;
    wr_addr_in = addr;
    wr_data_in = data;
  endtask

  task automatic rd(input logic [1:0] a, input logic [1:0] b);
    rd_a_addr_in = a;
    rd_b_addr_in = b;
  endtask

  initial begin
    // Reset held with a bypassing write presented: outputs must still be 0.
    reset_in = 1'b0;
    clear_in = 1'b0;
    wr(1'b1, 2'd1, 4'hA);
    rd(2'd1, 2'd1);
    #2;
    check("rst_a0", a0, 4'h0);
    check("rst_b0", b0, 4'h0);
    check("rst_az", az, 4'h0);
    check("rst_ar", ar, 4'h0);
    tick();
    tick();
    check("rst_edge_ar", ar, 4'h0);
    check("rst_edge_a1", a1, 4'h0);

    // Release, read every address.
    reset_in = 1'b1;
    wr(1'b0, 2'd0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), 2'(3 - i));
      #1;
      check("init_a0", a0, 4'h0);
      check("init_b0", b0, 4'h0);
    end
    tick();
    check("init_ar", ar, 4'h0);

    // Write 0xA to addr 1, read both ports next cycle.
    wr(1'b1, 2'd1, 4'hA);
    rd(2'd0, 2'd0);
    tick();
    wr(1'b0, 2'd0, 4'h0);
    rd(2'd1, 2'd1);
    #1;
    check("wr_a0", a0, 4'hA);
    check("wr_b0", b0, 4'hA);
    check("wr_a1", a1, 4'hA);
    check("wr_az", az, 4'hA);
    check("wr_ar_lat", ar, 4'h0);
    tick();
    check("wr_ar", ar, 4'hA);
    check("wr_br", br, 4'hA);

    // Same-cycle bypass of 0x5 to addr 2.
    wr(1'b1, 2'd2, 4'h5);
    rd(2'd2, 2'd1);
    #1;
    check("byp_a0", a0, 4'h5);
    check("byp_a1_old", a1, 4'h0);
    check("byp_b0", b0, 4'hA);
    tick();
    wr(1'b0, 2'd0, 4'h0);
    #1;
    check("byp_a1_new", a1, 4'h5);
    check("byp_a0_new", a0, 4'h5);
    check("byp_ar", ar, 4'h5);

    // Write 0xF to addr 0: zero entry ignores it, others store it.
    wr(1'b1, 2'd0, 4'hF);
    rd(2'd0, 2'd0);
    #1;
    check("zero_byp_az", az, 4'h0);
    check("zero_byp_a0", a0, 4'hF);
    tick();
    wr(1'b0, 2'd0, 4'h0);
    #1;
    check("zero_az", az, 4'h0);
    check("zero_bz", bz, 4'h0);
    check("zero_a0", a0, 4'hF);

    // Fill 1..4, then clear with a competing write of 0x7 to addr 3.
    for (int i = 0; i < 4; i++) begin
      wr(1'b1, 2'(i), 4'(i + 1));
      tick();
    end
    wr(1'b0, 2'd0, 4'h0);
    rd(2'd3, 2'd2);
    #1;
    check("fill_a0", a0, 4'h4);
    check("fill_b0", b0, 4'h3);
    check("fill_bz", bz, 4'h3);
    clear_in = 1'b1;
    wr(1'b1, 2'd3, 4'h7);
    #1;
    check("clr_nobyp_a0", a0, 4'h4);
    tick();
    clear_in = 1'b0;
    wr(1'b0, 2'd0, 4'h0);
    #1;
    check("clr_ar", ar, 4'h0);
    check("clr_br", br, 4'h0);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), 2'(i));
      #1;
      check("clr_a0", a0, 4'h0);
      check("clr_a1", a1, 4'h0);
    end
    tick();

    // Write 0x9 to addr 3, then pulse reset between edges.
    wr(1'b1, 2'd3, 4'h9);
    rd(2'd3, 2'd3);
    tick();
    wr(1'b0, 2'd0, 4'h0);
    #1;
    check("pre_rst_a0", a0, 4'h9);
    tick();
    check("pre_rst_ar", ar, 4'h9);
    wr(1'b1, 2'd2, 4'h6);
    reset_in = 1'b0;
    #1;
    check("arst_a0", a0, 4'h0);
    check("arst_b1", b1, 4'h0);
    check("arst_ar", ar, 4'h0);
    check("arst_br", br, 4'h0);
    wr(1'b0, 2'd0, 4'h0);
    reset_in = 1'b1;
    #1;
    check("post_rst_a0", a0, 4'h0);
    rd(2'd2, 2'd3);
    #1;
    check("post_rst_a0_2", a0, 4'h0);
    tick();
    check("post_rst_br", br, 4'h0);
    check("post_rst_b1", b1, 4'h0);

    // First edge after release writes normally.
    wr(1'b1, 2'd3, 4'hC);
    tick();
    wr(1'b0, 2'd0, 4'h0);
    #1;
    check("post_rst_wr_b0", b0, 4'hC);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
